// File: rtl/ctrl_pkg.sv
// Shared definitions for the gen2 control FSM: state encoding, condition codes,
// flag positions, instruction field constants and the registered output bundle.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET   = 5'd0,
    S_FETCH_1 = 5'd1,
    S_FETCH_2 = 5'd2,
    S_R_TYPE  = 5'd3,
    S_LOAD_1  = 5'd4,
    S_LOAD_2  = 5'd5,
    S_STORE_1 = 5'd6,
    S_STORE_2 = 5'd7,
    S_JUMP_1  = 5'd8,
    S_JUMP_2  = 5'd9,
    S_JAL_1   = 5'd10,
    S_JAL_2   = 5'd11,
    S_JAL_3   = 5'd12,
    S_PAD_1   = 5'd13,
    S_PAD_2   = 5'd14,
    S_PAD_3   = 5'd15,
    S_STOP    = 5'd16
  } state_e;

  // Flag vector positions within flags[4:0]
  localparam int unsigned FLAG_Z = 4;
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_L = 0;

  // Jump condition codes
  localparam logic [3:0] COND_Z  = 4'b0000;
  localparam logic [3:0] COND_NZ = 4'b0001;
  localparam logic [3:0] COND_C  = 4'b0010;
  localparam logic [3:0] COND_NC = 4'b0011;
  localparam logic [3:0] COND_L  = 4'b0100;
  localparam logic [3:0] COND_NL = 4'b0101;
  localparam logic [3:0] COND_N  = 4'b0110;
  localparam logic [3:0] COND_NN = 4'b0111;
  localparam logic [3:0] COND_F  = 4'b1000;
  localparam logic [3:0] COND_NF = 4'b1001;
  localparam logic [3:0] COND_HI = 4'b1010;  // !L & !Z
  localparam logic [3:0] COND_LS = 4'b1011;  // L | Z
  localparam logic [3:0] COND_GT = 4'b1100;  // !N & !Z
  localparam logic [3:0] COND_LE = 4'b1101;  // N | Z
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Instruction field constants
  localparam logic [3:0] OP_MEM      = 4'b0100;
  localparam logic [3:0] SUBOP_LOAD  = 4'b0000;
  localparam logic [3:0] SUBOP_STORE = 4'b0100;
  localparam logic [3:0] SUBOP_JAL   = 4'b1000;
  localparam logic [3:0] SUBOP_JUMP  = 4'b1100;
  localparam logic [3:0] SUBOP_PAD   = 4'b1111;
  localparam logic [3:0] OP_MOVI     = 4'b1101;
  localparam logic [3:0] OP_LUI      = 4'b1111;
  localparam logic [3:0] OP_CMPI     = 4'b1011;
  localparam logic [3:0] OP_RTYPE    = 4'b0000;
  localparam logic [3:0] FN_CMP      = 4'b1011;

  typedef struct packed {
    logic [15:0] opcode;
    logic [15:0] reg_en;
    logic [3:0]  mux_a_sel;
    logic [3:0]  mux_b_sel;
    logic        alu_sel;
    logic        pc_sel;
    logic        mem_w_en_a;
    logic        flag_en;
    logic        pc_en;
    logic        pc_ld;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_IDLE = '{
    opcode:     16'h0000,
    reg_en:     16'h0000,
    mux_a_sel:  4'h0,
    mux_b_sel:  4'h0,
    alu_sel:    1'b1,
    pc_sel:     1'b1,
    mem_w_en_a: 1'b0,
    flag_en:    1'b0,
    pc_en:      1'b0,
    pc_ld:      1'b0
  };

endpackage

// File: rtl/cond_eval.sv
// Combinational jump-condition evaluator: condition code + ALU flags -> take.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       take
);

  logic z, c, f, n, l;

  // Decode the condition code against the current flags
  always_comb begin
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    f = flags[FLAG_F];
    n = flags[FLAG_N];
    l = flags[FLAG_L];
    take = 1'b0;
    case (cond)
      COND_Z:  take = z;
      COND_NZ: take = ~z;
      COND_C:  take = c;
      COND_NC: take = ~c;
      COND_L:  take = l;
      COND_NL: take = ~l;
      COND_N:  take = n;
      COND_NN: take = ~n;
      COND_F:  take = f;
      COND_NF: take = ~f;
      COND_HI: take = ~l & ~z;
      COND_LS: take = l | z;
      COND_GT: take = ~n & ~z;
      COND_LE: take = n | z;
      COND_UC: take = 1'b1;
      COND_NV: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/onehot16.sv
// 4-to-16 one-hot decoder for register write enables.
module onehot16 (
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  // Set exactly the bit selected by idx
  always_comb begin
    onehot = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/ctrl_fsm_gen2.sv
// Second-generation multi-cycle control FSM for the 16-bit CPU datapath.
// All outputs are registered: the values chosen while in a state appear
// after the edge that leaves that state.
module ctrl_fsm_gen2
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_PADS   = 2,
  parameter int unsigned PAD_BITS   = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  mem_in,
  input  logic                         mem_ready,
  input  logic [4:0]                   flags,
  input  logic [ADDR_WIDTH-1:0]        pc_ins,
  input  logic [NUM_PADS*PAD_BITS-1:0] pad_data,
  input  logic                         resume,
  output logic [15:0]                  opcode,
  output logic [15:0]                  reg_en,
  output logic [3:0]                   mux_A_sel,
  output logic [3:0]                   mux_B_sel,
  output logic                         alu_sel,
  output logic                         pc_sel,
  output logic                         mem_w_en_a,
  output logic                         flag_en,
  output logic                         pc_en,
  output logic                         pc_ld,
  output logic                         halted,
  output logic                         illegal
);

  state_e    state_q, state_d;
  ctrl_out_t out_q, out_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  old_hi_q, old_hi_d;
  logic [7:0]  pad_hi_q, pad_hi_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  logic        take;
  logic [15:0] rd_onehot;
  logic        is_cmp;
  logic [15:0] pc_ext;
  logic [15:0] pad_ext;

  cond_eval u_cond (
    .cond  (instr_q[11:8]),
    .flags (flags),
    .take  (take)
  );

  onehot16 u_rd_dec (
    .idx    (instr_q[11:8]),
    .onehot (rd_onehot)
  );

  // Zero-extend the fetched PC and select the addressed gamepad word (0 if out of range)
  always_comb begin
    pc_ext = '0;
    pc_ext[ADDR_WIDTH-1:0] = pc_ins;
    pad_ext = '0;
    for (int unsigned k = 0; k < NUM_PADS; k++) begin
      if ({28'd0, instr_q[3:0]} == k) pad_ext[PAD_BITS-1:0] = pad_data[k*PAD_BITS +: PAD_BITS];
    end
  end

  // Compare instructions update flags but never write a register
  always_comb begin
    is_cmp = ((instr_q[15:12] == OP_RTYPE) && (instr_q[7:4] == FN_CMP)) ||
             (instr_q[15:12] == OP_CMPI);
  end

  // Next-state and next-output logic; unlisted outputs hold their previous value
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    instr_d   = instr_q;
    old_hi_d  = old_hi_q;
    pad_hi_d  = pad_hi_q;
    halted_d  = halted_q;
    illegal_d = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH_1;
      S_FETCH_1: begin
        out_d       = CTRL_IDLE;
        out_d.pc_en = 1'b1;
        state_d     = S_FETCH_2;
      end
      S_FETCH_2: begin
        out_d.pc_en = 1'b0;
        if (mem_ready) begin
          instr_d = mem_in;
          if (mem_in == 16'h0000) begin
            state_d  = S_STOP;
            halted_d = 1'b1;
          end else if (mem_in[15:12] != OP_MEM) begin
            state_d = S_R_TYPE;
          end else begin
            case (mem_in[7:4])
              SUBOP_LOAD:  state_d = S_LOAD_1;
              SUBOP_STORE: state_d = S_STORE_1;
              SUBOP_JAL:   state_d = S_JAL_1;
              SUBOP_JUMP:  state_d = S_JUMP_1;
              SUBOP_PAD:   state_d = S_PAD_1;
              default: begin
                illegal_d = 1'b1;
                state_d   = S_FETCH_1;
              end
            endcase
          end
        end
      end
      // JAL_2/PAD_2 issue the synthesized MOVI like an R-type, minus flag update
      S_R_TYPE, S_JAL_2, S_PAD_2: begin
        out_d.opcode    = instr_q;
        out_d.mux_a_sel = instr_q[11:8];
        out_d.mux_b_sel = instr_q[3:0];
        out_d.reg_en    = is_cmp ? 16'h0000 : rd_onehot;
        out_d.flag_en   = (state_q == S_R_TYPE);
        if (state_q == S_R_TYPE) begin
          state_d = S_FETCH_1;
        end else begin
          out_d.pc_ld = 1'b0;
          out_d.pc_en = 1'b0;
          state_d     = (state_q == S_JAL_2) ? S_JAL_3 : S_PAD_3;
        end
      end
      S_STORE_1: begin
        out_d.mux_a_sel  = instr_q[3:0];
        out_d.mux_b_sel  = instr_q[11:8];
        out_d.pc_sel     = 1'b0;
        out_d.mem_w_en_a = 1'b1;
        state_d          = S_STORE_2;
      end
      S_STORE_2: begin
        out_d.pc_sel     = 1'b1;
        out_d.mem_w_en_a = 1'b0;
        state_d          = S_FETCH_1;
      end
      S_LOAD_1: begin
        out_d.mux_a_sel = instr_q[3:0];
        out_d.pc_sel    = 1'b0;
        out_d.reg_en    = rd_onehot;
        state_d         = S_LOAD_2;
      end
      S_LOAD_2: begin
        out_d.alu_sel = 1'b0;
        out_d.pc_sel  = 1'b1;
        state_d       = S_FETCH_1;
      end
      S_JUMP_1: begin
        out_d.pc_ld     = take;
        out_d.pc_en     = take;
        out_d.mux_a_sel = instr_q[3:0];
        state_d         = S_JUMP_2;
      end
      S_JUMP_2: begin
        out_d.pc_ld = 1'b0;
        out_d.pc_en = 1'b0;
        state_d     = S_FETCH_1;
      end
      S_JAL_1: begin
        out_d.pc_ld     = 1'b1;
        out_d.pc_en     = 1'b1;
        out_d.mux_a_sel = instr_q[3:0];
        old_hi_d        = pc_ext[15:8];
        instr_d         = {OP_MOVI, instr_q[11:8], pc_ins[7:0]};
        state_d         = S_JAL_2;
      end
      S_JAL_3: begin
        instr_d = {OP_LUI, instr_q[11:8], old_hi_q};
        state_d = S_R_TYPE;
      end
      S_PAD_1: begin
        pad_hi_d = pad_ext[15:8];
        instr_d  = {OP_MOVI, instr_q[11:8], pad_ext[7:0]};
        state_d  = S_PAD_2;
      end
      S_PAD_3: begin
        instr_d = {OP_LUI, instr_q[11:8], pad_hi_q};
        state_d = S_R_TYPE;
      end
      S_STOP: begin
        out_d    = CTRL_IDLE;
        halted_d = ~resume;
        if (resume) state_d = S_FETCH_1;
      end
      default: state_d = S_RESET;
    endcase
  end

  // State, instruction and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      out_q     <= CTRL_IDLE;
      instr_q   <= '0;
      old_hi_q  <= '0;
      pad_hi_q  <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      instr_q   <= instr_d;
      old_hi_q  <= old_hi_d;
      pad_hi_q  <= pad_hi_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign opcode     = out_q.opcode;
  assign reg_en     = out_q.reg_en;
  assign mux_A_sel  = out_q.mux_a_sel;
  assign mux_B_sel  = out_q.mux_b_sel;
  assign alu_sel    = out_q.alu_sel;
  assign pc_sel     = out_q.pc_sel;
  assign mem_w_en_a = out_q.mem_w_en_a;
  assign flag_en    = out_q.flag_en;
  assign pc_en      = out_q.pc_en;
  assign pc_ld      = out_q.pc_ld;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_ctrl_fsm_gen2.sv
// Directed self-checking bench for ctrl_fsm_gen2 (3 pads x 12 bits, 12-bit PC).
module tb_ctrl_fsm_gen2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_in;
  logic        mem_ready;
  logic [4:0]  flags;
  logic [11:0] pc_ins;
  logic [35:0] pad_data;
  logic        resume;
  logic [15:0] opcode, reg_en;
  logic [3:0]  mux_A_sel, mux_B_sel;
  logic        alu_sel, pc_sel, mem_w_en_a, flag_en, pc_en, pc_ld, halted, illegal;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_fsm_gen2 #(.ADDR_WIDTH(12), .NUM_PADS(3), .PAD_BITS(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_in     (mem_in),
    .mem_ready  (mem_ready),
    .flags      (flags),
    .pc_ins     (pc_ins),
    .pad_data   (pad_data),
    .resume     (resume),
    .opcode     (opcode),
    .reg_en     (reg_en),
    .mux_A_sel  (mux_A_sel),
    .mux_B_sel  (mux_B_sel),
    .alu_sel    (alu_sel),
    .pc_sel     (pc_sel),
    .mem_w_en_a (mem_w_en_a),
    .flag_en    (flag_en),
    .pc_en      (pc_en),
    .pc_ld      (pc_ld),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From FETCH_2: issue a conditional jump and check pc_ld/pc_en after JUMP_1
  task automatic do_jump(input logic [15:0] ins, input logic [4:0] fl, input logic exp_take);
    mem_in = ins;
    flags  = fl;
    step();                       // -> JUMP_1
    step();                       // -> JUMP_2, JUMP_1 outputs visible
    chk("jump_pc_ld", pc_ld, exp_take);
    chk("jump_pc_en", pc_en, exp_take);
    chk("jump_muxA", mux_A_sel, ins[3:0]);
    step();                       // -> FETCH_1
    chk("jump2_pc_ld", pc_ld, 0);
    step();                       // -> FETCH_2
  endtask

  // From FETCH_2: read a gamepad channel and check the MOVI/LUI pair
  task automatic do_pad(input logic [15:0] ins, input logic [15:0] movi,
                        input logic [15:0] lui, input logic [15:0] rd_en);
    mem_in = ins;
    step();                       // -> PAD_1
    step();                       // -> PAD_2
    step();                       // -> PAD_3, PAD_2 outputs visible
    chk("pad_movi", opcode, movi);
    chk("pad_movi_en", reg_en, rd_en);
    chk("pad_movi_flag", flag_en, 0);
    step();                       // -> R_TYPE
    step();                       // -> FETCH_1, LUI visible
    chk("pad_lui", opcode, lui);
    chk("pad_lui_en", reg_en, rd_en);
    step();                       // -> FETCH_2
  endtask

  initial begin
    reset     = 1'b1;
    mem_in    = 16'h0000;
    mem_ready = 1'b0;
    flags     = 5'b00000;
    pc_ins    = 12'h3A7;
    pad_data  = {12'hABC, 12'h123, 12'h456};
    resume    = 1'b0;
    #12;
    chk("rst_opcode", opcode, 16'h0000);
    chk("rst_reg_en", reg_en, 16'h0000);
    chk("rst_alu_sel", alu_sel, 1);
    chk("rst_pc_sel", pc_sel, 1);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_halted", halted, 0);

    @(negedge clk);
    reset = 1'b0;
    step();                       // RESET -> FETCH_1
    chk("post_rst_pc_en", pc_en, 0);
    step();                       // FETCH_1 -> FETCH_2
    chk("f1_pc_en", pc_en, 1);
    mem_in = 16'h1203;
    for (int i = 0; i < 3; i++) begin
      step();                     // held in FETCH_2
      chk("wait_pc_en", pc_en, 0);
      chk("wait_opcode", opcode, 16'h0000);
    end
    mem_ready = 1'b1;
    step();                       // -> R_TYPE
    step();                       // -> FETCH_1
    chk("r_opcode", opcode, 16'h1203);
    chk("r_reg_en", reg_en, 16'h0004);
    chk("r_flag_en", flag_en, 1);
    chk("r_muxB", mux_B_sel, 4'h3);
    step();                       // -> FETCH_2
    chk("r_flag_once", flag_en, 0);
    chk("r_pc_en", pc_en, 1);

    // CMPI and R-type CMP: flags only
    mem_in = 16'hB305;
    step(); step();
    chk("cmpi_flag_en", flag_en, 1);
    chk("cmpi_reg_en", reg_en, 16'h0000);
    step();
    mem_in = 16'h04B1;
    step(); step();
    chk("cmp_opcode", opcode, 16'h04B1);
    chk("cmp_reg_en", reg_en, 16'h0000);
    step();

    // Conditional jumps
    do_jump(16'h43C5, 5'b01000, 1'b0);   // !C with C=1, Z=0
    do_jump(16'h40C2, 5'b10000, 1'b1);   // Z with Z=1
    do_jump(16'h4AC4, 5'b00001, 1'b0);   // !L&!Z with L=1
    do_jump(16'h4DC0, 5'b00010, 1'b1);   // N|Z with N=1
    do_jump(16'h4FC1, 5'b11111, 1'b0);   // never

    // JAL
    mem_in = 16'h4A85;
    step();                       // -> JAL_1
    step();                       // -> JAL_2
    chk("jal_pc_ld", pc_ld, 1);
    chk("jal_pc_en", pc_en, 1);
    chk("jal_muxA", mux_A_sel, 4'h5);
    step();                       // -> JAL_3
    chk("jal_movi", opcode, 16'hDAA7);
    chk("jal_movi_en", reg_en, 16'h0400);
    chk("jal2_pc_ld", pc_ld, 0);
    step();                       // -> R_TYPE
    step();                       // -> FETCH_1
    chk("jal_lui", opcode, 16'hFA03);
    chk("jal_lui_en", reg_en, 16'h0400);
    step();

    // Gamepad reads: valid channel and out-of-range channel
    do_pad(16'h45F2, 16'hD5BC, 16'hF50A, 16'h0020);
    do_pad(16'h45F7, 16'hD500, 16'hF500, 16'h0020);
    do_pad(16'h45F0, 16'hD556, 16'hF504, 16'h0020);

    // Store
    mem_in = 16'h4B43;
    step(); step();               // -> STORE_2
    chk("st_mem_w", mem_w_en_a, 1);
    chk("st_pc_sel", pc_sel, 0);
    chk("st_muxA", mux_A_sel, 4'h3);
    chk("st_muxB", mux_B_sel, 4'hB);
    step();                       // -> FETCH_1
    chk("st2_mem_w", mem_w_en_a, 0);
    chk("st2_pc_sel", pc_sel, 1);
    step();

    // Load
    mem_in = 16'h4702;
    step(); step();               // -> LOAD_2
    chk("ld_reg_en", reg_en, 16'h0080);
    chk("ld_pc_sel", pc_sel, 0);
    chk("ld_muxA", mux_A_sel, 4'h2);
    step();                       // -> FETCH_1
    chk("ld2_alu_sel", alu_sel, 0);
    chk("ld2_pc_sel", pc_sel, 1);
    step();
    chk("ld_alu_restore", alu_sel, 1);

    // Illegal sub-op
    mem_in = 16'h4A25;
    step();                       // -> FETCH_1
    chk("ill_pulse", illegal, 1);
    step();                       // -> FETCH_2
    chk("ill_clear", illegal, 0);
    chk("ill_pc_en", pc_en, 1);

    // STOP and resume; resume pulse outside STOP is ignored
    mem_in = 16'h0000;
    step();                       // -> STOP
    chk("stop_halted", halted, 1);
    chk("stop_pc_en", pc_en, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stop_hold", halted, 1);
    end
    resume = 1'b1;
    step();                       // -> FETCH_1
    resume = 1'b0;
    chk("resume_halted", halted, 0);
    mem_in = 16'h4B43;
    step();                       // -> FETCH_2
    chk("resume_pc_en", pc_en, 1);

    // Reset mid-store
    step(); step();               // -> STORE_2
    chk("mid_st_mem_w", mem_w_en_a, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_mem_w", mem_w_en_a, 0);
    chk("async_pc_sel", pc_sel, 1);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();                       // RESET -> FETCH_1
    chk("rerst_pc_en0", pc_en, 0);
    step();                       // -> FETCH_2
    chk("rerst_pc_en1", pc_en, 1);
    step();
    chk("rerst_pc_en2", pc_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
